mul4_tile_sched: RTL and testbench

MUL4_TILE_SCHED -- requirements
Module: mul4_tile_sched

---
 rtl/mul4_tile_sched_pkg.sv | 27 ++
 rtl/mul4_tile_sched_if.sv | 23 ++
 rtl/mul4_tile_sched_mul2x2_core.sv | 20 ++
 rtl/mul4_tile_sched.sv | 88 ++++++++
 tb/tb_mul4_tile_sched.sv | 153 +++++++++++++++
 5 files changed

// File: rtl/mul4_tile_sched_pkg.sv
// Shared types and constants for the 4x4 tiled multiplier scheduler.
package mul4_tile_sched_pkg;

    localparam int OP_W   = 4;
    localparam int DIG_W  = 2;
    localparam int PROD_W = 8;
    localparam int TILES  = 4;
    localparam int CNT_W  = 2;
    localparam int PP_W   = 2 * DIG_W;

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_e;

    // Entry i is the left shift applied to tile i.
    localparam logic [TILES-1:0][2:0] TILE_SHIFT = {3'd4, 3'd2, 3'd2, 3'd0};

    function automatic logic [PROD_W-1:0] place_tile(
        input logic [PP_W-1:0]  pp,
        input logic [CNT_W-1:0] idx
    );
        return {{(PROD_W-PP_W){1'b0}}, pp} << TILE_SHIFT[idx];
    endfunction

endpackage

// File: rtl/mul4_tile_sched_if.sv
// Operand/product handshake bundle for mul4_tile_sched.
interface mul4_tile_sched_if;
    import mul4_tile_sched_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [OP_W-1:0]   A;
    logic [OP_W-1:0]   B;
    logic              out_valid;
    logic              out_ready;
    logic [PROD_W-1:0] P;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, P
    );

    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, P
    );

endinterface

// File: rtl/mul4_tile_sched_mul2x2_core.sv
// Combinational 2x2 unsigned multiplier built from its partial products.
module mul2x2_core (
    input  logic [1:0] a,
    input  logic [1:0] b,
    output logic [3:0] p
);

    logic pp00, pp01, pp10, pp11;

    assign pp00 = a[0] & b[0];
    assign pp10 = a[1] & b[0];
    assign pp01 = a[0] & b[1];
    assign pp11 = a[1] & b[1];

    assign p = {3'b000, pp00}
             + {2'b00, pp10, 1'b0}
             + {2'b00, pp01, 1'b0}
             + {1'b0, pp11, 2'b00};

endmodule

// File: rtl/mul4_tile_sched.sv
// 4x4 unsigned multiplier: four 2x2 tiles through one shared core,
// one tile per cycle, result held until the consumer takes it.
module mul4_tile_sched
    import mul4_tile_sched_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    mul4_tile_sched_if.slave  bus
);

    state_e             state_q, state_d;
    logic [OP_W-1:0]    a_q, a_d;
    logic [OP_W-1:0]    b_q, b_d;
    logic [PROD_W-1:0]  acc_q, acc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [DIG_W-1:0]   a_dig, b_dig;
    logic [PP_W-1:0]    pp;

    // Tile order: lo*lo, lo*hi, hi*lo, hi*hi (A digit, B digit).
    always_comb begin
        a_dig = a_q[DIG_W-1:0];
        b_dig = b_q[DIG_W-1:0];
        unique case (cnt_q)
            2'd0: begin a_dig = a_q[1:0]; b_dig = b_q[1:0]; end
            2'd1: begin a_dig = a_q[1:0]; b_dig = b_q[3:2]; end
            2'd2: begin a_dig = a_q[3:2]; b_dig = b_q[1:0]; end
            2'd3: begin a_dig = a_q[3:2]; b_dig = b_q[3:2]; end
            default: ;
        endcase
    end

    mul2x2_core u_core (
        .a (a_dig),
        .b (b_dig),
        .p (pp)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.A;
                    b_d     = bus.B;
                    acc_d   = '0;
                    cnt_d   = '0;
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_q + place_tile(pp, cnt_q);
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CNT_W'(TILES - 1))
                    state_d = DONE;
            end
            DONE: begin
                if (bus.out_ready)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.P         = (state_q == DONE) ? acc_q : '0;

endmodule

// File: tb/tb_mul4_tile_sched.sv
// Randomized self-checking bench for mul4_tile_sched against A*B.
module tb_mul4_tile_sched;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_err;
    int   n_acc;
    int   n_xfer;

    mul4_tile_sched_if bus ();

    mul4_tile_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    always @(posedge clk)
        if (!rst && bus.out_valid && bus.out_ready)
            n_xfer++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One transaction: accept, four busy cycles, hold for 'stall' cycles, release.
    task automatic run_txn(
        input logic [3:0] a,
        input logic [3:0] b,
        input int         stall,
        input bit         hold
    );
        int          waitc;
        logic [7:0]  exp;
        exp   = 8'(a) * 8'(b);
        waitc = 0;
        while (!bus.in_ready && waitc < 20) begin
            @(negedge clk);
            waitc++;
        end
        check("accept_ready", 32'(bus.in_ready), 32'd1);
        bus.A        = a;
        bus.B        = b;
        bus.in_valid = 1'b1;
        @(negedge clk);
        n_acc++;
        for (int k = 1; k <= 4; k++) begin
            check("calc_in_ready", 32'(bus.in_ready), 32'd0);
            check("calc_out_valid", 32'(bus.out_valid), 32'd0);
            check("calc_P", 32'(bus.P), 32'd0);
            if (hold) begin
                bus.A = 4'($urandom);
                bus.B = 4'($urandom);
            end else begin
                bus.in_valid = 1'b0;
            end
            bus.out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        check("done_out_valid", 32'(bus.out_valid), 32'd1);
        check("done_P", 32'(bus.P), 32'(exp));
        check("done_in_ready", 32'(bus.in_ready), 32'd0);
        for (int s = 0; s < stall; s++) begin
            bus.out_ready = 1'b0;
            if (hold) begin
                bus.A = 4'($urandom);
                bus.B = 4'($urandom);
            end
            @(negedge clk);
            check("stall_out_valid", 32'(bus.out_valid), 32'd1);
            check("stall_P", 32'(bus.P), 32'(exp));
            check("stall_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b0;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check("rel_out_valid", 32'(bus.out_valid), 32'd0);
        check("rel_in_ready", 32'(bus.in_ready), 32'd1);
        check("rel_P", 32'(bus.P), 32'd0);
        check("xfer_count", 32'(n_xfer), 32'(n_acc));
    endtask

    initial begin
        n_chk  = 0;
        n_err  = 0;
        n_acc  = 0;
        n_xfer = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.A         = 4'd5;
        bus.B         = 4'd5;
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd1);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_P", 32'(bus.P), 32'd0);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        @(negedge clk);

        run_txn(4'd15, 4'd15, 0, 1'b0);
        run_txn(4'd3, 4'd2, 0, 1'b0);
        run_txn(4'd0, 4'd9, 0, 1'b0);
        run_txn(4'd10, 4'd6, 7, 1'b0);
        run_txn(4'd9, 4'd7, 2, 1'b1);

        // Abort during tile2, with in_valid asserted to show rst wins.
        bus.A        = 4'd13;
        bus.B        = 4'd11;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst           = 1'b1;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge clk);
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_P", 32'(bus.P), 32'd0);
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            check("abort_quiet", 32'(bus.out_valid), 32'd0);
        end
        bus.out_ready = 1'b0;
        run_txn(4'd2, 4'd3, 0, 1'b0);

        for (int i = 0; i < 256; i++)
            run_txn(4'(i >> 4), 4'(i), int'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
